// File: rtl/painel_pkg.sv
// Shared definitions for the LED matrix scan path.
// Latency: none (constants, types and a pure function only).
// Backpressure: not applicable.
// Contents: matrix geometry, scan FSM state enum, idle row-select
// pattern and a helper that builds the active-low one-hot row select.
package painel_pkg;

   localparam int NLINHAS  = 5;
   localparam int NCOLUNAS = 7;

   // Row select is active-low, so "no row" is all ones.
   localparam logic [NLINHAS-1:0] SEL_NENHUMA = 5'b11111;

   typedef enum logic [1:0] {IDLE, LOAD, BLANK, SHOW} estado_t;

   // Active-low one-hot select for row index idx (0..NLINHAS-1).
   function automatic logic [NLINHAS-1:0] sel_de(input logic [2:0] idx);
      logic [NLINHAS-1:0] s;
      s      = SEL_NENHUMA;
      s[idx] = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/pwm_brilho.sv
// Brightness PWM: lights columns for the first 'nivel' cycles of every 16 SHOW cycles.
// Latency: combinational decision for the next cycle; phase counter updates on CLK.
// Backpressure: none; follows the scan FSM unconditionally.
// Ports: CLK, RST (sync, active-high); avanca = next cycle is another cycle
// of the same SHOW slot; nivel = brightness 0..15; aceso_n = columns lit next cycle.
module pwm_brilho (
   input  logic       CLK,
   input  logic       RST,
   input  logic       avanca,
   input  logic [3:0] nivel,
   output logic       aceso_n
);

   // fase holds the SHOW-cycle count (mod 16) of the current cycle.
   logic [3:0] fase;
   logic [3:0] fase_n;

   // The first SHOW cycle after a blank restarts the phase at 0.
   always_comb begin
      fase_n = avanca ? fase + 4'd1 : 4'd0;
   end

   assign aceso_n = (fase_n < nivel);

   always_ff @(posedge CLK) begin
      if (RST) begin
         fase <= 4'd0;
      end else begin
         fase <= fase_n;
      end
   end

endmodule

// File: rtl/varredura_matriz.sv
// Row-multiplexed scan of a 5x7 LED matrix with a per-frame snapshot of the row data.
// Latency: outputs registered (Moore); first lit cycle 1+BLANK cycles after LOAD.
// Backpressure: none; en is only sampled in IDLE and on the last cycle of a frame.
// Ports: CLK, RST (sync, active-high), en, linha1..linha5 (bit 0 = leftmost, 1 = on);
// sel_linha (active-low one-hot), colunas (1 = lit), linha_atual (0..4), quadro_fim.
// Option: define BRILHO_EN to add the 4-bit brilho input (PWM duty brilho/16 while shown).
module varredura_matriz
   import painel_pkg::*;
#(
   parameter int DWELL = 1000,
   parameter int BLANK = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                en,
   input  logic [NCOLUNAS-1:0] linha1,
   input  logic [NCOLUNAS-1:0] linha2,
   input  logic [NCOLUNAS-1:0] linha3,
   input  logic [NCOLUNAS-1:0] linha4,
   input  logic [NCOLUNAS-1:0] linha5,
`ifdef BRILHO_EN
   input  logic [3:0]          brilho,
`endif
   output logic [NLINHAS-1:0]  sel_linha,
   output logic [NCOLUNAS-1:0] colunas,
   output logic [2:0]          linha_atual,
   output logic                quadro_fim
);

   localparam int CW = $clog2(DWELL);
   localparam logic [CW-1:0] ULT_BLANK = CW'(BLANK - 1);
   localparam logic [CW-1:0] ULT_SHOW  = CW'(DWELL - BLANK - 1);
   localparam logic [2:0]    ULT_LINHA = 3'(NLINHAS - 1);

   estado_t             estado, estado_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic [2:0]          linha_n;
   logic [NLINHAS-1:0]  sel_n;
   logic [NCOLUNAS-1:0] col_n;
   logic                fim_n;
   logic                aceso_n;

   logic [NCOLUNAS-1:0] entrada [NLINHAS];
   logic [NCOLUNAS-1:0] quadro  [NLINHAS];

   always_comb begin
      entrada[0] = linha1;
      entrada[1] = linha2;
      entrada[2] = linha3;
      entrada[3] = linha4;
      entrada[4] = linha5;
   end

`ifdef BRILHO_EN
   logic [3:0] nivel;

   pwm_brilho u_pwm (
      .CLK     (CLK),
      .RST     (RST),
      .avanca  ((estado == painel_pkg::SHOW) && (estado_n == painel_pkg::SHOW)),
      .nivel   (nivel),
      .aceso_n (aceso_n)
   );
`else
   assign aceso_n = 1'b1;
`endif

   // Next state and next-cycle outputs. Outputs are derived from the next
   // state so that they change on the same edge as the state register.
   always_comb begin
      estado_n = estado;
      linha_n  = linha_atual;
      unique case (estado)
         painel_pkg::IDLE: begin
            if (en) begin
               estado_n = painel_pkg::LOAD;
               linha_n  = 3'd0;
            end
         end
         painel_pkg::LOAD: begin
            estado_n = painel_pkg::BLANK;
         end
         painel_pkg::BLANK: begin
            if (cnt == ULT_BLANK) begin
               estado_n = painel_pkg::SHOW;
            end
         end
         painel_pkg::SHOW: begin
            if (cnt == ULT_SHOW) begin
               if (linha_atual == ULT_LINHA) begin
                  // Frame end: en decides whether another frame follows.
                  // linha_atual holds its value when going idle.
                  if (en) begin
                     estado_n = painel_pkg::LOAD;
                     linha_n  = 3'd0;
                  end else begin
                     estado_n = painel_pkg::IDLE;
                  end
               end else begin
                  estado_n = painel_pkg::BLANK;
                  linha_n  = linha_atual + 3'd1;
               end
            end
         end
         default: estado_n = painel_pkg::IDLE;
      endcase

      // Dwell counter restarts on every state change and stays parked in IDLE.
      if ((estado_n != estado) || (estado == painel_pkg::IDLE)) begin
         cnt_n = '0;
      end else begin
         cnt_n = cnt + 1'b1;
      end

      sel_n = SEL_NENHUMA;
      col_n = '0;
      if (estado_n == painel_pkg::SHOW) begin
         sel_n = sel_de(linha_n);
         if (aceso_n) begin
            col_n = quadro[linha_n];
         end
      end

      fim_n = (estado_n == painel_pkg::SHOW) && (cnt_n == ULT_SHOW) &&
              (linha_n == ULT_LINHA);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         estado      <= painel_pkg::IDLE;
         cnt         <= '0;
         linha_atual <= 3'd0;
         sel_linha   <= SEL_NENHUMA;
         colunas     <= '0;
         quadro_fim  <= 1'b0;
         for (int i = 0; i < NLINHAS; i++) begin
            quadro[i] <= '0;
         end
`ifdef BRILHO_EN
         nivel       <= 4'd0;
`endif
      end else begin
         estado      <= estado_n;
         cnt         <= cnt_n;
         linha_atual <= linha_n;
         sel_linha   <= sel_n;
         colunas     <= col_n;
         quadro_fim  <= fim_n;
         // Snapshot taken during the single LOAD cycle; the buffer is
         // never read on that edge because the next state is BLANK.
         if (estado == painel_pkg::LOAD) begin
            for (int i = 0; i < NLINHAS; i++) begin
               quadro[i] <= entrada[i];
            end
`ifdef BRILHO_EN
            nivel <= brilho;
`endif
         end
      end
   end

endmodule

// File: tb/tb_varredura_matriz.sv
// Bench for varredura_matriz: frame-position model plus directed literal checks.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_varredura_matriz;

`ifdef BRILHO_EN
   localparam int D = 18;
`else
   localparam int D = 8;
`endif
   localparam int B   = 2;
   localparam int P1  = 1 + B;            // first lit cycle after LOAD
   localparam int R3  = 1 + 2 * D + B;    // first lit cycle of row 3
   localparam int FIM = 5 * D;            // last cycle of the frame
   localparam int FR  = 5 * D + 1;        // frame period

   logic       CLK = 1'b0;
   logic       RST;
   logic       en;
   logic [6:0] l1, l2, l3, l4, l5;
   logic [3:0] brilho;
   logic [4:0] sel_linha;
   logic [6:0] colunas;
   logic [2:0] linha_atual;
   logic       quadro_fim;

   int ncmp = 0;
   int nerr = 0;

   always #5 CLK = ~CLK;

   varredura_matriz #(.DWELL(D), .BLANK(B)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .en          (en),
      .linha1      (l1),
      .linha2      (l2),
      .linha3      (l3),
      .linha4      (l4),
      .linha5      (l5),
`ifdef BRILHO_EN
      .brilho      (brilho),
`endif
      .sel_linha   (sel_linha),
      .colunas     (colunas),
      .linha_atual (linha_atual),
      .quadro_fim  (quadro_fim)
   );

   task automatic chk(input string nome, input logic [6:0] act, input logic [6:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", nome, act, exp, $time);
      end
   endtask

   // Model: pos = cycles since the last LOAD (LOAD itself is 0), -1 = idle.
   int         pos   = -1;
   bit         valido = 1'b0;
   logic [6:0] snap [5];
   int         nivel_m = 16;
   logic [2:0] la_m = 3'd0;

   always @(posedge CLK) begin
      int np;
      np = pos;
      if (RST) begin
         np = -1;
      end else if (pos < 0) begin
         if (en) np = 0;
      end else if (pos == 0) begin
         snap[0] <= l1; snap[1] <= l2; snap[2] <= l3; snap[3] <= l4; snap[4] <= l5;
`ifdef BRILHO_EN
         nivel_m <= int'(brilho);
`endif
         np = 1;
      end else if (pos == FIM) begin
         np = en ? 0 : -1;
      end else begin
         np = pos + 1;
      end
      pos <= np;
      if (RST) begin
         valido <= 1'b1;
         la_m   <= 3'd0;
      end else if (np == 0) begin
         la_m <= 3'd0;
      end else if (np > 0) begin
         la_m <= 3'((np - 1) / D);
      end
   end

   always @(negedge CLK) begin
      logic [4:0] e_sel;
      logic [6:0] e_col;
      logic       e_fim;
      int         r, o;
      e_sel = 5'b11111;
      e_col = 7'd0;
      e_fim = 1'b0;
      if (pos >= 1) begin
         r = (pos - 1) / D;
         o = (pos - 1) % D;
         if (o >= B) begin
            e_sel    = 5'b11111;
            e_sel[r] = 1'b0;
            if (((o - B) % 16) < nivel_m) e_col = snap[r];
         end
         e_fim = (r == 4) && (o == D - 1);
      end
      if (valido) begin
         chk("sel_linha", 7'(sel_linha), 7'(e_sel));
         chk("colunas", colunas, e_col);
         chk("quadro_fim", 7'(quadro_fim), 7'(e_fim));
         chk("linha_atual", 7'(linha_atual), 7'(la_m));
      end
   end

   task automatic ciclos(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      RST = 1'b1; en = 1'b1; brilho = 4'd4;
      l1 = 7'b1110111; l2 = 7'b0001000; l3 = 7'b1111111;
      l4 = 7'b0000001; l5 = 7'b1010101;
      ciclos(2);
      chk("rst_sel", 7'(sel_linha), 7'b0011111);
      chk("rst_col", colunas, 7'd0);
      chk("rst_fim", 7'(quadro_fim), 7'd0);
      chk("rst_linha", 7'(linha_atual), 7'd0);
      RST = 1'b0;

      // Nominal frame: LOAD, first lit row, snapshot protection, frame end.
      ciclos(1);
      chk("load_sel", 7'(sel_linha), 7'b0011111);
      chk("load_linha", 7'(linha_atual), 7'd0);
      ciclos(P1);
      chk("row1_sel", 7'(sel_linha), 7'b0011110);
      chk("row1_col", colunas, 7'b1110111);
      ciclos(2);
      l3 = 7'b0000000;
      ciclos(R3 - P1 - 2);
      chk("row3_sel", 7'(sel_linha), 7'b0011011);
      chk("row3_snap_col", colunas, 7'b1111111);
      chk("row3_linha", 7'(linha_atual), 7'd2);
      ciclos(FIM - R3);
      chk("fim_pulse", 7'(quadro_fim), 7'd1);
      chk("fim_sel", 7'(sel_linha), 7'b0001111);
      ciclos(1);
      chk("fim_one_cycle", 7'(quadro_fim), 7'd0);
      chk("reload_sel", 7'(sel_linha), 7'b0011111);
      ciclos(R3);
      chk("row3_new_col", colunas, 7'b0000000);

      // Enable drop during row 2 of the third frame.
      ciclos(FR - R3);
      ciclos(1 + D + B + 1);
      en = 1'b0;
      ciclos(FIM - (1 + D + B + 1));
      chk("drop_fim", 7'(quadro_fim), 7'd1);
      ciclos(1);
      chk("idle_sel", 7'(sel_linha), 7'b0011111);
      chk("idle_col", colunas, 7'd0);
      ciclos(3 * D);
      chk("idle_stays_sel", 7'(sel_linha), 7'b0011111);

      // Reset during row 4 SHOW, then restart with fresh data.
      en = 1'b1;
      ciclos(1);
      ciclos(1 + 3 * D + B + 1);
      chk("row4_sel", 7'(sel_linha), 7'b0010111);
      chk("row4_linha", 7'(linha_atual), 7'd3);
      RST = 1'b1;
      l1  = 7'b0101010;
      ciclos(1);
      chk("mid_rst_sel", 7'(sel_linha), 7'b0011111);
      chk("mid_rst_col", colunas, 7'd0);
      chk("mid_rst_linha", 7'(linha_atual), 7'd0);
      RST = 1'b0;
      ciclos(1);
      ciclos(P1);
      chk("restart_sel", 7'(sel_linha), 7'b0011110);
      chk("restart_col", colunas, 7'b0101010);

`ifdef BRILHO_EN
      // Zero brightness: rows still scan, columns stay dark.
      brilho = 4'd0;
      ciclos(2 * FR);
`else
      ciclos(FR);
`endif
      en = 1'b0;
      ciclos(FR + 5);

      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
      $finish;
   end

endmodule
